// File: rtl/mag_stats_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mag_stats_pkg
// Description : Shared types and constants for the magnitude window-statistics
//               stage: FSM state enum, sample width and sum-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mag_stats_pkg;

  localparam int MAG_W = 8;

  typedef enum logic [0:0] {
    ST_BELOW = 1'b0,
    ST_ABOVE = 1'b1
  } stats_state_t;

  // A window of 2^win_log2 samples of MAG_W bits sums without overflow in this width
  function automatic int sum_width(input int win_log2);
    return MAG_W + win_log2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mag_window_stats_if.sv
`default_nettype none
// ============================================================================
// Interface   : mag_window_stats_if
// Description : Sample stream, control and status bundle between the
//               magnitude stage / status consumer (master) and the
//               window-statistics block (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mag_window_stats_if;

  logic       ena;
  logic       mag_valid;
  logic [7:0] mag_in;
  logic [7:0] thresh;
  logic       clear;
  logic [7:0] avg_out;
  logic [7:0] peak_out;
  logic       win_full;
  logic       stats_valid;
  logic       over_evt;
  logic       above;

  modport master (
    output ena, mag_valid, mag_in, thresh, clear,
    input  avg_out, peak_out, win_full, stats_valid, over_evt, above
  );

  modport slave (
    input  ena, mag_valid, mag_in, thresh, clear,
    output avg_out, peak_out, win_full, stats_valid, over_evt, above
  );

endinterface
`default_nettype wire

// File: rtl/mag_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mag_ring_buffer
// Description : 2^WIN_LOG2-deep ring of magnitude samples. Presents the entry
//               about to be overwritten (the oldest) combinationally so the
//               running sum can retire it in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mag_ring_buffer
  import mag_stats_pkg::*;
#(
  parameter int WIN_LOG2 = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic             wr_en,
  input  wire logic [MAG_W-1:0] wr_data,
  output      logic [MAG_W-1:0] oldest
);

  localparam int DEPTH = 1 << WIN_LOG2;

  logic [MAG_W-1:0]    mem [DEPTH];
  logic [WIN_LOG2-1:0] wr_ptr;

  // Pointer wraps naturally at DEPTH; zeroed entries make the fill phase uniform
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  assign oldest = mem[wr_ptr];

endmodule
`default_nettype wire

// File: rtl/mag_window_stats.sv
`default_nettype none
// ============================================================================
// Module      : mag_window_stats
// Description : Sliding-window moving average, peak hold and hysteretic
//               over-threshold event on the 8-bit magnitude stream.
//               Optional feature macro: MAG_STATS_PEAK_EN (peak-hold register;
//               when undefined peak_out is tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module mag_window_stats
  import mag_stats_pkg::*;
#(
  parameter int WIN_LOG2 = 3,
  parameter int HYST     = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  mag_window_stats_if.slave bus
);

  localparam int                DEPTH  = 1 << WIN_LOG2;
  localparam int                SUM_W  = sum_width(WIN_LOG2);
  localparam int                CNT_W  = WIN_LOG2 + 1;
  localparam logic [MAG_W-1:0]  HYST_V = MAG_W'(HYST);
  localparam logic [CNT_W-1:0]  FULL_V = CNT_W'(DEPTH);

  logic             accept;
  logic             flush;
  logic [MAG_W-1:0] oldest;
  logic [MAG_W-1:0] avg;
  logic [MAG_W-1:0] fall_level;
  logic             full;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic             stats_valid_r;
  logic             over_evt_r;
  stats_state_t     state;

  // clear only acts in enabled cycles, since ena low ignores every input
  assign accept = bus.ena & bus.mag_valid & ~bus.clear;
  assign flush  = bus.ena & bus.clear;

  mag_ring_buffer #(.WIN_LOG2(WIN_LOG2)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .wr_en   (accept),
    .wr_data (bus.mag_in),
    .oldest  (oldest)
  );

  // Always divide by full depth, so fill-phase averages ramp up from zero
  assign avg  = sum[SUM_W-1:WIN_LOG2];
  assign full = (count == FULL_V);

  // Falling threshold clamps at zero; with thresh < HYST the ABOVE state is sticky
  assign fall_level = (bus.thresh >= HYST_V) ? (bus.thresh - HYST_V) : '0;

  // Running sum retires the overwritten entry; count saturates at depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum           <= '0;
      count         <= '0;
      stats_valid_r <= 1'b0;
    end else begin
      stats_valid_r <= accept;
      if (flush) begin
        sum   <= '0;
        count <= '0;
      end else if (accept) begin
        sum <= sum + SUM_W'(bus.mag_in) - SUM_W'(oldest);
        if (!full) count <= count + 1'b1;
      end
    end
  end

  // Threshold FSM looks at the registered average, so it trails the sum by one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BELOW;
      over_evt_r <= 1'b0;
    end else begin
      over_evt_r <= 1'b0;
      if (bus.ena) begin
        if (bus.clear) begin
          state <= ST_BELOW;
        end else begin
          case (state)
            ST_BELOW: if (full && (avg > bus.thresh)) begin
              state      <= ST_ABOVE;
              over_evt_r <= 1'b1;
            end
            ST_ABOVE: if (avg < fall_level) state <= ST_BELOW;
            default:  state <= ST_BELOW;
          endcase
        end
      end
    end
  end

`ifdef MAG_STATS_PEAK_EN
  logic [MAG_W-1:0] peak;

  // Peak hold since reset or clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak <= '0;
    end else if (flush) begin
      peak <= '0;
    end else if (accept && (bus.mag_in > peak)) begin
      peak <= bus.mag_in;
    end
  end

  assign bus.peak_out = peak;
`else
  assign bus.peak_out = '0;
`endif

  assign bus.avg_out     = avg;
  assign bus.win_full    = full;
  assign bus.stats_valid = stats_valid_r;
  assign bus.over_evt    = over_evt_r;
  assign bus.above       = (state == ST_ABOVE);

endmodule
`default_nettype wire

// File: tb/tb_mag_window_stats.sv
`default_nettype none
// ============================================================================
// Module      : tb_mag_window_stats
// Description : Directed, table-driven bench for mag_window_stats
//               (WIN_LOG2 = 3, HYST = 4). Honours MAG_STATS_PEAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mag_window_stats;

`ifdef MAG_STATS_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  typedef struct {
    bit       ena;
    bit       valid;
    bit [7:0] mag;
    bit [7:0] thr;
    bit       clr;
    int       avg;
    int       peak;
    bit       full;
    bit       sv;
    bit       evt;
    bit       abv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  vec_t vecs [100];
  int   n_vec = 0;

  mag_window_stats_if bus ();

  mag_window_stats #(.WIN_LOG2(3), .HYST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit ena, input bit valid, input int mag, input int thr,
                     input bit clr, input int avg, input int peak, input bit full,
                     input bit sv, input bit evt, input bit abv);
    vecs[n_vec] = '{ena, valid, 8'(mag), 8'(thr), clr, avg, peak, full, sv, evt, abv};
    n_vec++;
  endtask

  task automatic drive(input bit ena, input bit valid, input int mag, input int thr, input bit clr);
    bus.ena       = ena;
    bus.mag_valid = valid;
    bus.mag_in    = 8'(mag);
    bus.thresh    = 8'(thr);
    bus.clear     = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pk(input int v);
    return PEAK_EN ? v : 0;
  endfunction

  task automatic chk_all(input string tag, input int avg, input int peak, input bit full,
                         input bit sv, input bit evt, input bit abv);
    chk({tag, " avg"},   int'(bus.avg_out),     avg);
    chk({tag, " peak"},  int'(bus.peak_out),    pk(peak));
    chk({tag, " full"},  int'(bus.win_full),    int'(full));
    chk({tag, " sv"},    int'(bus.stats_valid), int'(sv));
    chk({tag, " evt"},   int'(bus.over_evt),    int'(evt));
    chk({tag, " above"}, int'(bus.above),       int'(abv));
  endtask

  initial begin
    int hyst_fill [8] = '{1, 3, 4, 6, 7, 9, 10, 12};
    int hyst_8s   [8] = '{11, 11, 10, 10, 9, 9, 8, 8};
    int refill    [8] = '{5, 6, 6, 7, 7, 9, 10, 12};

    // Fill with 16: avg 2,4,..,16, full on the 8th accept
    for (int k = 1; k <= 8; k++) add(1, 1, 16, 255, 0, 2 * k, 16, k == 8, 1, 0, 0);
    // Slide zeros in: avg 14,12,..,0, peak holds 16
    for (int k = 1; k <= 8; k++) add(1, 1, 0, 255, 0, 16 - 2 * k, 16, 1, 1, 0, 0);
    // clear beats mag_valid, then an idle cycle shows no stats_valid
    add(1, 1, 99, 255, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 255, 0, 0, 0, 0, 0, 0, 0);
    // Hysteresis, thresh 10: fill with 12
    for (int k = 0; k < 8; k++) add(1, 1, 12, 10, 0, hyst_fill[k], 12, k == 7, 1, 0, 0);
    // Feed 8: event shows on the first one, above holds down to avg 8
    for (int k = 0; k < 8; k++) add(1, 1, 8, 10, 0, hyst_8s[k], 12, 1, 1, k == 0, 1);
    // Feed 0: avg 7,6,5 -- still above until FSM sees 5 < 6
    add(1, 1, 0, 10, 0, 7, 12, 1, 1, 0, 1);
    add(1, 1, 0, 10, 0, 6, 12, 1, 1, 0, 1);
    add(1, 1, 0, 10, 0, 5, 12, 1, 1, 0, 1);
    // Refill with 12: FSM drops out on the first, re-arms at avg 12
    for (int k = 0; k < 8; k++) add(1, 1, 12, 10, 0, refill[k], 12, 1, 1, 0, k != 0 ? 1'b0 : 1'b0);
    add(1, 0, 0, 10, 0, 12, 12, 1, 0, 1, 1);
    // ena low with valid high and a threshold that would force BELOW: all frozen
    for (int k = 0; k < 5; k++) add(0, 1, 200, 255, 0, 12, 12, 1, 0, 0, 1);
    // ena back: FSM now sees 12 < 251 and leaves ABOVE
    add(1, 0, 0, 255, 0, 12, 12, 1, 0, 0, 0);

    // Reset state
    drive(0, 0, 0, 255, 0);
    rst = 1'b1;
    step();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i].ena, vecs[i].valid, vecs[i].mag, vecs[i].thr, vecs[i].clr);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].avg, vecs[i].peak, vecs[i].full,
              vecs[i].sv, vecs[i].evt, vecs[i].abv);
    end

    // Reset mid-fill: 3 samples of 50, asynchronous reset between edges
    drive(1, 1, 0, 255, 1);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 50, 255, 0);
      step();
    end
    chk("midfill avg", int'(bus.avg_out), 18);
    drive(1, 0, 0, 255, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 8, 255, 0);
    step();
    chk_all("post_rst", 1, 8, 0, 1, 0, 0);

    // thresh below HYST: ABOVE is sticky even once the average reaches 0
    drive(1, 0, 0, 2, 1);
    step();
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 16, 2, 0);
      step();
    end
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 0, 2, 0);
      step();
    end
    drive(1, 0, 0, 2, 0);
    step();
    step();
    chk("sticky avg", int'(bus.avg_out), 0);
    chk("sticky above", int'(bus.above), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
